// File: rtl/jt49_dcrm.sv
// jt49_dcrm: decimating DC-removal stage for the PSG sound word.
// The PSG sample is decimated on cen, then a first-order EMA of the input
// is subtracted, giving a saturated signed 10-bit sample with a valid strobe.
// Optional build macro JT49_DCRM_PRELOAD_EN: the first sample after reset
// seeds the average instead of being filtered, avoiding the start-up transient.
module jt49_dcrm #(
    parameter int unsigned DECIM = 1,   // cen ticks per output sample, 1..256
    parameter int unsigned SHIFT = 8    // EMA alpha = 2^-SHIFT, 2..12
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic [9:0] din,
    output logic [9:0] dout,
    output logic       dout_vld,
    output logic [9:0] avg
);

    localparam int unsigned AW = 10 + SHIFT;
    localparam int unsigned CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DECIM - 1);
    localparam logic [AW-1:0] ACC_MAX  = AW'(1023) << SHIFT;

`ifdef JT49_DCRM_PRELOAD_EN
    typedef enum logic {INIT, RUN} state_t;
    state_t state_q;
`endif

    logic [CW-1:0] cnt_q;
    logic [9:0]    xs_q;
    logic          st1_q;
    logic [AW-1:0] acc_q, acc_d;
    logic [9:0]    dout_q, dout_d;
    logic [9:0]    avg_q, avg_d;
    logic          vld_q;

    logic [9:0]        avg_cur;
    logic signed [10:0] diff;
    logic [AW:0]       acc_sum;

    // Stage 1: decimation counter and sample capture on the last cen tick
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            xs_q  <= '0;
            st1_q <= 1'b0;
        end else begin
            st1_q <= 1'b0;
            if (cen) begin
                if (cnt_q == CNT_LAST) begin
                    cnt_q <= '0;
                    xs_q  <= din;
                    st1_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign avg_cur = acc_q[AW-1:SHIFT];
    assign diff    = $signed({1'b0, xs_q}) - $signed({1'b0, avg_cur});
    assign acc_sum = {1'b0, acc_q} + (AW+1)'(xs_q) - (AW+1)'(avg_cur);

    // Stage 2 next-state: EMA update and saturated difference (or preload)
    always_comb begin
        acc_d = acc_sum[AW-1:0];
        if (diff > 11'sd511)
            dout_d = 10'h1FF;
        else if (diff < -11'sd512)
            dout_d = 10'h200;
        else
            dout_d = diff[9:0];
`ifdef JT49_DCRM_PRELOAD_EN
        if (state_q == INIT) begin
            acc_d  = {xs_q, {SHIFT{1'b0}}};
            dout_d = '0;
        end
`endif
        avg_d = acc_d[AW-1:SHIFT];
    end

    // Stage 2 registers: commit one filtered sample the clk after capture
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            dout_q  <= '0;
            avg_q   <= '0;
            vld_q   <= 1'b0;
`ifdef JT49_DCRM_PRELOAD_EN
            state_q <= INIT;
`endif
        end else begin
            vld_q <= st1_q;
            if (st1_q) begin
                acc_q  <= acc_d;
                dout_q <= dout_d;
                avg_q  <= avg_d;
`ifdef JT49_DCRM_PRELOAD_EN
                state_q <= RUN;
`endif
            end
        end
    end

    assign dout     = dout_q;
    assign dout_vld = vld_q;
    assign avg      = avg_q;

    // Accumulator never exceeds 1023*2^SHIFT, so the update cannot carry out
    a_acc_bound: assert property (@(posedge clk) disable iff (rst) acc_q <= ACC_MAX);
    a_no_carry:  assert property (@(posedge clk) disable iff (rst) !(st1_q && acc_sum[AW]));

endmodule

// File: tb/tb_jt49_dcrm.sv
// Scoreboard bench for jt49_dcrm: two instances (DECIM=1/SHIFT=4 and
// DECIM=4/SHIFT=8) share clk, rst and din; each has its own cen.
module tb_jt49_dcrm;

`ifdef JT49_DCRM_PRELOAD_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen0 = 1'b0, cen1 = 1'b0;
    logic [9:0] din = '0;
    logic [9:0] dout0, avg0, dout1, avg1;
    logic       vld0, vld1;

    jt49_dcrm #(.DECIM(1), .SHIFT(4)) u0 (
        .clk(clk), .rst(rst), .cen(cen0), .din(din),
        .dout(dout0), .dout_vld(vld0), .avg(avg0)
    );

    jt49_dcrm #(.DECIM(4), .SHIFT(8)) u1 (
        .clk(clk), .rst(rst), .cen(cen1), .din(din),
        .dout(dout1), .dout_vld(vld1), .avg(avg1)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int due;
        int d;
        int a;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   acc_m[2];
    int   tick_m[2];
    bit   first_m[2];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   ecount = 0;
    int   rst_chk = -1;

    always @(posedge clk) ecount <= ecount + 1;

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            acc_m[u]   = 0;
            tick_m[u]  = 0;
            first_m[u] = 1'b1;
        end
    endtask

    // Reference: every DECIM-th cen tick yields a sample x; output is
    // clamp(x - floor(acc/2^S)) and acc moves by x - floor(acc/2^S).
    task automatic model_sample(input int u, input int x, input int e);
        int   s;
        int   dec;
        int   avgp;
        exp_t t;
        s   = (u == 0) ? 4 : 8;
        dec = (u == 0) ? 1 : 4;
        tick_m[u]++;
        if (tick_m[u] < dec) return;
        tick_m[u] = 0;
        avgp = acc_m[u] / (1 << s);
        if (PRE && first_m[u]) begin
            acc_m[u] = x * (1 << s);
            t.d = 0;
        end else begin
            t.d = x - avgp;
            if (t.d > 511) t.d = 511;
            if (t.d < -512) t.d = -512;
            acc_m[u] = acc_m[u] + x - avgp;
        end
        first_m[u] = 1'b0;
        t.a   = acc_m[u] / (1 << s);
        t.due = e + 1;
        if (u == 0) q0.push_back(t);
        else        q1.push_back(t);
    endtask

    // Drive inputs for the next edge and record the expected response
    task automatic step(input bit r, input bit c0, input bit c1, input int x);
        int e;
        e    = ecount + 1;
        rst  = r;
        cen0 = c0;
        cen1 = c1;
        din  = 10'(x);
        if (r) begin
            while (q0.size() > 0 && q0[$].due == e) void'(q0.pop_back());
            while (q1.size() > 0 && q1[$].due == e) void'(q1.pop_back());
            model_reset();
            rst_chk = e;
        end else begin
            if (c0) model_sample(0, x, e);
            if (c1) model_sample(1, x, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_unit(input int u, input logic vld, input logic [9:0] d,
                              input logic [9:0] a, input int k);
        exp_t t;
        bit   have;
        if (rst_chk == k) begin
            n_cmp++;
            if (vld !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_vld u%0d edge %0d: got %b want 0", u, k, vld);
            end
            n_cmp++;
            if (d !== 10'd0 || a !== 10'd0) begin
                n_bad++;
                $display("FAIL rst_outs u%0d edge %0d: got dout=%0d avg=%0d want 0/0", u, k, d, a);
            end
        end
        have = (u == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) t = (u == 0) ? q0[0] : q1[0];
        if (vld === 1'b1) begin
            n_cmp++;
            if (!have) begin
                n_bad++;
                $display("FAIL spurious_vld u%0d edge %0d: got vld=1 want 0", u, k);
            end else begin
                if (u == 0) void'(q0.pop_front());
                else        void'(q1.pop_front());
                if (t.due != k || int'($signed(d)) != t.d || int'(a) != t.a) begin
                    n_bad++;
                    $display("FAIL sample u%0d edge %0d: got edge=%0d dout=%0d avg=%0d want edge=%0d dout=%0d avg=%0d",
                             u, k, k, int'($signed(d)), int'(a), t.due, t.d, t.a);
                end
            end
        end else if (have && t.due <= k) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missed_vld u%0d edge %0d: got vld=%b want 1 (dout=%0d)", u, k, vld, t.d);
            if (u == 0) void'(q0.pop_front());
            else        void'(q1.pop_front());
        end
    endtask

    // Monitor: compare outputs mid-cycle, away from the active edge
    always @(negedge clk) begin
        check_unit(0, vld0, dout0, avg0, ecount);
        check_unit(1, vld1, dout1, avg1, ecount);
    end

    initial begin
        model_reset();
        @(posedge clk);
        #1;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        // Constant mid-scale input, unit1 cen every 3rd clk
        for (int i = 0; i < 60; i++) step(0, 1'b1, (i % 3) == 0, 512);

        // Step 100 -> 300
        step(1, 0, 0, 0);
        for (int i = 0; i < 40; i++) step(0, 1'b1, 1'b1, (i < 4) ? 100 : 300);

        // Full-scale swings: 1023 -> 0 -> 1023
        step(1, 0, 0, 0);
        for (int i = 0; i < 60; i++)
            step(0, 1'b1, 1'b1, (i < 4) ? 1023 : ((i < 24) ? 0 : 1023));

        // Reset one clk after a sampling cen; the next sample restarts filtering
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b1, 700);
        step(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) step(0, 1'b1, 1'b1, 200 + 50 * i);

        // Random din, random cen gaps, occasional reset
        for (int i = 0; i < 800; i++) begin
            bit r;
            r = ($urandom_range(0, 99) == 0);
            step(r, $urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                 int'($urandom_range(0, 1023)));
        end

        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);

        n_cmp++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d/%0d pending want 0/0", q0.size(), q1.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
